if_id_queue: RTL and testbench

Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry instruction queue between the fetch stage and the decode stage, decoupling fetch from decode stalls. Fetch pushes (pc, inst) pairs under a valid/ready handshake, and decode pops them in order under its own valid/ready handshake. A flush (branch/jump redirect) empties the queue in one cycle, and an empty queue presents a zero bubble to decode.

---
 rtl/if_id_queue_pkg.sv | 21 ++
 rtl/if_id_queue_if.sv | 20 ++
 rtl/if_id_queue_mem.sv | 30 +++
 rtl/if_id_queue.sv | 131 +++++++++++++
 tb/tb_if_id_queue.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg
//   Shared widths and constants for the IF/ID instruction queue, plus the
//   per-cycle operation code used by the queue's pointer/count control.
//   No ports (package).
package if_id_queue_pkg;

   localparam int       InstAddrBus = 32;
   localparam int       InstBus     = 32;
   localparam logic     RstEnable   = 1'b1;
   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   // What the queue does at the coming clock edge.
   typedef enum logic [2:0] {
      OP_IDLE  = 3'd0,
      OP_PUSH  = 3'd1,
      OP_POP   = 3'd2,
      OP_BOTH  = 3'd3,
      OP_FLUSH = 3'd4
   } q_op_e;

endpackage

// File: rtl/if_id_queue_if.sv
// if_id_queue_if
//   Valid/ready instruction bus carrying a (pc, inst) pair.
//   master: drives valid, pc, inst; samples ready.
//   slave : samples valid, pc, inst; drives ready.
interface if_id_queue_if
   import if_id_queue_pkg::*;
#(
   parameter int ADDR_W = InstAddrBus,
   parameter int INST_W = InstBus
) ();

   logic              valid;
   logic              ready;
   logic [ADDR_W-1:0] pc;
   logic [INST_W-1:0] inst;

   modport master (output valid, output pc, output inst, input ready);
   modport slave  (input valid, input pc, input inst, output ready);

endinterface

// File: rtl/if_id_queue_mem.sv
// if_id_queue_mem
//   DEPTH x (ADDR_W+INST_W) storage for the instruction queue. One
//   synchronous write port, one asynchronous read port. Not reset: stale
//   contents are masked by the queue's occupancy count.
//   Ports: clk, we, waddr, wdata (write); raddr, rdata (read).
module if_id_queue_mem #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [ADDR_W+INST_W-1:0]   wdata,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [ADDR_W+INST_W-1:0]   rdata
);

   logic [ADDR_W+INST_W-1:0] mem_r [DEPTH];

   // Write port: store the accepted (pc, inst) pair.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue
//   DEPTH-entry in-order instruction queue between fetch and decode.
//   Ports:
//     clk, rst   - clock, asynchronous active-high reset
//     flush_i    - drop all entries at the next edge (beats push and pop)
//     fetch      - slave side of the fetch bus (valid/pc/inst in, ready out)
//     decode     - master side of the decode bus (valid/pc/inst out, ready in)
//     count_o    - current occupancy
//   Every output depends only on registered state; an empty queue shows a
//   zero bubble to decode.
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int ADDR_W = InstAddrBus,
   parameter int INST_W = InstBus,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   if_id_queue_if.slave             fetch,
   if_id_queue_if.master            decode,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [PTR_W-1:0]          wr_ptr_r;
   logic [PTR_W-1:0]          rd_ptr_r;
   logic [CNT_W-1:0]          count_r;
   logic                      full_s;
   logic                      empty_s;
   logic                      push_s;
   logic                      pop_s;
   q_op_e                     op_s;
   logic [ADDR_W+INST_W-1:0]  head_s;

   assign full_s  = (count_r == CNT_FULL);
   assign empty_s = (count_r == {CNT_W{1'b0}});

   // ready is taken from the count alone, so a pop on a full queue cannot
   // open the door for a push in the same cycle.
   assign push_s = fetch.valid && !full_s && !flush_i;
   assign pop_s  = !empty_s && decode.ready && !flush_i;

   // Classify this cycle's operation; flush dominates everything.
   always_comb begin
      op_s = OP_IDLE;
      if (flush_i) begin
         op_s = OP_FLUSH;
      end else if (push_s && pop_s) begin
         op_s = OP_BOTH;
      end else if (push_s) begin
         op_s = OP_PUSH;
      end else if (pop_s) begin
         op_s = OP_POP;
      end else begin
         op_s = OP_IDLE;
      end
   end

   // Pointer and occupancy state; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         case (op_s)
            OP_FLUSH: begin
               wr_ptr_r <= {PTR_W{1'b0}};
               rd_ptr_r <= {PTR_W{1'b0}};
               count_r  <= {CNT_W{1'b0}};
            end
            OP_PUSH: begin
               wr_ptr_r <= wr_ptr_r + PTR_ONE;
               count_r  <= count_r + CNT_ONE;
            end
            OP_POP: begin
               rd_ptr_r <= rd_ptr_r + PTR_ONE;
               count_r  <= count_r - CNT_ONE;
            end
            OP_BOTH: begin
               wr_ptr_r <= wr_ptr_r + PTR_ONE;
               rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            OP_IDLE: begin
               wr_ptr_r <= wr_ptr_r;
            end
            default: begin
               wr_ptr_r <= wr_ptr_r;
            end
         endcase
      end
   end

   if_id_queue_mem #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push_s),
      .waddr (wr_ptr_r),
      .wdata ({fetch.pc, fetch.inst}),
      .raddr (rd_ptr_r),
      .rdata (head_s)
   );

   assign fetch.ready  = !full_s;
   assign decode.valid = !empty_s;
   assign count_o      = count_r;

   // Head presentation: the stored pair when occupied, a zero bubble otherwise.
   always_comb begin
      decode.pc   = ADDR_W'(ZeroWord);
      decode.inst = INST_W'(ZeroWord);
      if (!empty_s) begin
         decode.pc   = head_s[ADDR_W+INST_W-1:INST_W];
         decode.inst = head_s[INST_W-1:0];
      end else begin
         decode.pc   = ADDR_W'(ZeroWord);
         decode.inst = INST_W'(ZeroWord);
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue
//   Scoreboard bench for if_id_queue at DEPTH=4 (32/32), DEPTH=2 and
//   DEPTH=8 (32/16). Stimulus queues each push it expects to be accepted,
//   tagged with the cycle it should first appear at the head; a negedge
//   monitor compares every DUT output against that queue.
module tb_if_id_queue;

   typedef struct {
      int          tag;
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   entry_t exp_q [3][$];

   logic        if_valid [3];
   logic [31:0] if_pc    [3];
   logic [31:0] if_inst  [3];
   logic        id_ready [3];
   logic        flush    [3];

   logic [2:0] cnt0;
   logic [1:0] cnt1;
   logic [3:0] cnt2;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   if_id_queue_if #(.ADDR_W(32), .INST_W(32)) f0 ();
   if_id_queue_if #(.ADDR_W(32), .INST_W(32)) d0 ();
   if_id_queue_if #(.ADDR_W(32), .INST_W(16)) f1 ();
   if_id_queue_if #(.ADDR_W(32), .INST_W(16)) d1 ();
   if_id_queue_if #(.ADDR_W(32), .INST_W(16)) f2 ();
   if_id_queue_if #(.ADDR_W(32), .INST_W(16)) d2 ();

   assign f0.valid = if_valid[0];
   assign f0.pc    = if_pc[0];
   assign f0.inst  = if_inst[0];
   assign d0.ready = id_ready[0];
   assign f1.valid = if_valid[1];
   assign f1.pc    = if_pc[1];
   assign f1.inst  = if_inst[1][15:0];
   assign d1.ready = id_ready[1];
   assign f2.valid = if_valid[2];
   assign f2.pc    = if_pc[2];
   assign f2.inst  = if_inst[2][15:0];
   assign d2.ready = id_ready[2];

   if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) u_q4 (
      .clk(clk), .rst(rst), .flush_i(flush[0]), .fetch(f0), .decode(d0), .count_o(cnt0));
   if_id_queue #(.ADDR_W(32), .INST_W(16), .DEPTH(2)) u_q2 (
      .clk(clk), .rst(rst), .flush_i(flush[1]), .fetch(f1), .decode(d1), .count_o(cnt1));
   if_id_queue #(.ADDR_W(32), .INST_W(16), .DEPTH(8)) u_q8 (
      .clk(clk), .rst(rst), .flush_i(flush[2]), .fetch(f2), .decode(d2), .count_o(cnt2));

   function automatic int depth_of(int k);
      return (k == 0) ? 4 : ((k == 1) ? 2 : 8);
   endfunction

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Compare one queue's outputs against the model, then retire this cycle's pop/flush.
   task automatic mon(int k, logic v, logic [31:0] pc, logic [31:0] inst, logic rdy, int cnt);
      int    vis;
      string nm;
      vis = 0;
      nm  = $sformatf("q%0d", depth_of(k));
      for (int i = 0; i < exp_q[k].size(); i++) begin
         if (exp_q[k][i].tag <= cyc) vis++;
      end
      check({nm, ".count"}, 32'(cnt), 32'(vis));
      check({nm, ".if_ready"}, {31'd0, rdy}, (vis != depth_of(k)) ? 32'd1 : 32'd0);
      check({nm, ".id_valid"}, {31'd0, v}, (vis != 0) ? 32'd1 : 32'd0);
      if (vis > 0) begin
         check({nm, ".id_pc"}, pc, exp_q[k][0].pc);
         check({nm, ".id_inst"}, inst, exp_q[k][0].inst);
      end else begin
         check({nm, ".bubble_pc"}, pc, 32'd0);
         check({nm, ".bubble_inst"}, inst, 32'd0);
      end
      if (flush[k]) begin
         exp_q[k].delete();
      end else if (vis > 0 && id_ready[k]) begin
         void'(exp_q[k].pop_front());
      end
   endtask

   // Monitor: sample mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         mon(0, d0.valid, d0.pc, d0.inst, f0.ready, int'(cnt0));
         mon(1, d1.valid, d1.pc, {16'h0000, d1.inst}, f1.ready, int'(cnt1));
         mon(2, d2.valid, d2.pc, {16'h0000, d2.inst}, f2.ready, int'(cnt2));
      end
   end

   // Drive one cycle on queue k and record the push if it should be accepted.
   task automatic step(int k, logic v, logic [31:0] pc, logic [31:0] inst, logic rdy, logic fl);
      entry_t e;
      @(posedge clk);
      #1;
      if_valid[k] = v;
      if_pc[k]    = pc;
      if_inst[k]  = inst;
      id_ready[k] = rdy;
      flush[k]    = fl;
      if (v && !fl && exp_q[k].size() < depth_of(k)) begin
         e.tag  = cyc + 1;
         e.pc   = pc;
         e.inst = (k == 0) ? inst : (inst & 32'h0000_FFFF);
         exp_q[k].push_back(e);
      end
   endtask

   task automatic check_drained(int k);
      check($sformatf("q%0d.drained", depth_of(k)), 32'(exp_q[k].size()), 32'd0);
   endtask

   // Fill past capacity with decode stalled, then drain to the bubble.
   task automatic fill_drain(int k);
      for (int i = 0; i <= depth_of(k); i++) begin
         step(k, 1'b1, 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 1'b0, 1'b0);
      end
      for (int i = 0; i <= depth_of(k) + 1; i++) begin
         step(k, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      end
      check_drained(k);
   endtask

   // Push and pop every cycle; occupancy holds at one and pointers wrap.
   task automatic stream(int k, int n);
      for (int i = 0; i < n; i++) begin
         step(k, 1'b1, 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
      end
      step(k, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      step(k, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      check_drained(k);
   endtask

   // Full queue with simultaneous pop: push refused that cycle, taken the next.
   task automatic full_pop(int k);
      for (int i = 0; i < depth_of(k); i++) begin
         step(k, 1'b1, 32'h100 + 32'(4 * i), 32'h0000_B000 + 32'(i), 1'b0, 1'b0);
      end
      step(k, 1'b1, 32'h0000_0050, 32'h0000_5050, 1'b1, 1'b0);
      step(k, 1'b1, 32'h0000_0050, 32'h0000_5050, 1'b0, 1'b0);
      for (int i = 0; i <= depth_of(k) + 1; i++) begin
         step(k, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      end
      check_drained(k);
   endtask

   task automatic reset_checks(string nm);
      check({nm, ".rst_count"}, {29'd0, cnt0}, 32'd0);
      check({nm, ".rst_valid"}, {31'd0, d0.valid}, 32'd0);
      check({nm, ".rst_pc"}, d0.pc, 32'd0);
      check({nm, ".rst_inst"}, d0.inst, 32'd0);
      check({nm, ".rst_ready"}, {31'd0, f0.ready}, 32'd1);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         if_valid[k] = 1'b0;
         if_pc[k]    = 32'd0;
         if_inst[k]  = 32'd0;
         id_ready[k] = 1'b0;
         flush[k]    = 1'b0;
      end
      #1 rst = 1'b1;
      #2 reset_checks("init");
      @(posedge clk);
      #1 rst = 1'b0;

      // DEPTH=4 directed scenarios.
      fill_drain(0);
      stream(0, 10);
      full_pop(0);

      // Flush with a push and a pop in the same cycle: 0x40 must never surface.
      step(0, 1'b1, 32'h0000_0030, 32'h3030_3030, 1'b0, 1'b0);
      step(0, 1'b1, 32'h0000_0034, 32'h3434_3434, 1'b0, 1'b0);
      step(0, 1'b1, 32'h0000_0040, 32'h4040_4040, 1'b1, 1'b1);
      step(0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      step(0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      check_drained(0);

      // Asynchronous reset with three entries held, checked before any edge.
      step(0, 1'b1, 32'h0000_0060, 32'h6060_6060, 1'b0, 1'b0);
      step(0, 1'b1, 32'h0000_0064, 32'h6464_6464, 1'b0, 1'b0);
      step(0, 1'b1, 32'h0000_0068, 32'h6868_6868, 1'b0, 1'b0);
      step(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1 reset_checks("mid");
      for (int k = 0; k < 3; k++) exp_q[k].delete();
      @(posedge clk);
      #1 rst = 1'b0;
      fill_drain(0);

      // Parameter sweep: DEPTH=2 and DEPTH=8 with 16-bit instructions.
      fill_drain(1);
      stream(1, 10);
      full_pop(1);
      fill_drain(2);
      stream(2, 10);
      full_pop(2);

      step(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
